// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, PC step and default reset PC.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter used for the optional fetch performance statistics.
module fetch_perf_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Sticks at all-ones rather than wrapping so long runs never read as small counts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner driving req/ack cache transactions and a decode-facing output register.
// Optional statistics outputs are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               icache_req,
    output logic [ADDR_W-1:0]  icache_addr,
    input  logic               icache_ack,
    input  logic [INSTR_W-1:0] icache_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_wait
`endif
);

    fetch_state_t       state_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic               req_reg;
    logic               valid_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [ADDR_W-1:0]  instr_pc_reg;
    logic [ADDR_W-1:0]  redirect_pc;

    assign redirect_pc = branch_target & ~ADDR_W'(3);

    // Redirect is checked first so a same-edge ack or decode handshake is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            req_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
        end else if (branch_taken) begin
            pc_reg    <= redirect_pc;
            valid_reg <= 1'b0;
            state_reg <= fetch_en ? FETCH : IDLE;
            req_reg   <= fetch_en;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fetch_en) begin
                        state_reg <= FETCH;
                        req_reg   <= 1'b1;
                    end
                end
                FETCH: begin
                    // fetch_en is ignored here: a presented request always runs to its ack.
                    if (icache_ack) begin
                        instr_reg    <= icache_data;
                        instr_pc_reg <= pc_reg;
                        valid_reg    <= 1'b1;
                        pc_reg       <= pc_reg + ADDR_W'(PC_INC);
                        state_reg    <= HOLD;
                        req_reg      <= 1'b0;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= fetch_en ? FETCH : IDLE;
                        req_reg   <= fetch_en;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign icache_req  = req_reg;
    assign icache_addr = pc_reg;
    assign instr_valid = valid_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [1:0]       perf_inc;
    logic [1:0][31:0] perf_count;

    // A handshake coinciding with a redirect is not a delivery, so it is not counted.
    assign perf_inc[0] = valid_reg && instr_ready && !branch_taken;
    assign perf_inc[1] = req_reg && !icache_ack;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            fetch_perf_counter #(.W(32)) u_counter (
                .clock (clock),
                .reset (reset),
                .inc   (perf_inc[gi]),
                .count (perf_count[gi])
            );
        end
    endgenerate

    assign perf_fetched = perf_count[0];
    assign perf_wait    = perf_count[1];
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; statistics checks apply when FETCH_PERF_CNT_EN is defined.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ack;
    logic [31:0] icache_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_wait;
`endif

    int compared   = 0;
    int mismatched = 0;

    fetch_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_ack    (icache_ack),
        .icache_data   (icache_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_wait     (perf_wait)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within 100000 ns");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return 32'hA5A0_0000 ^ a;
    endfunction

    initial begin
        logic [31:0] a;
        reset = 1'b1; fetch_en = 1'b0; branch_taken = 1'b0; branch_target = '0;
        icache_ack = 1'b0; icache_data = '0; instr_ready = 1'b0;
        step(); step();
        chk("rst_req", {31'd0, icache_req}, 32'd0);
        chk("rst_addr", icache_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        reset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
        step();

        // Back-to-back single-cycle acks: addresses 0,4,8,0xC.
        for (int i = 0; i < 4; i++) begin
            a = 32'(i * 4);
            $display("fetch1 addr=%h", a);
            chk("seq_req", {31'd0, icache_req}, 32'd1);
            chk("seq_addr", icache_addr, a);
            chk("seq_valid_low", {31'd0, instr_valid}, 32'd0);
            icache_ack = 1'b1; icache_data = word_for(a);
            step();
            chk("seq_valid", {31'd0, instr_valid}, 32'd1);
            chk("seq_instr_pc", instr_pc, a);
            chk("seq_instr", instr, word_for(a));
            chk("seq_req_low", {31'd0, icache_req}, 32'd0);
            step();
        end

        // Three wait cycles at 0x10.
        chk("wait_addr0", icache_addr, 32'h10);
        for (int j = 0; j < 3; j++) begin
            icache_ack = 1'b0;
            step();
            $display("wait cycle %0d", j);
            chk("wait_req", {31'd0, icache_req}, 32'd1);
            chk("wait_addr", icache_addr, 32'h10);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        icache_ack = 1'b1; icache_data = word_for(32'h10); instr_ready = 1'b0;
        step();
        chk("wait_done_valid", {31'd0, instr_valid}, 32'd1);
        chk("wait_done_pc", instr_pc, 32'h10);
        chk("wait_next_addr", icache_addr, 32'h14);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_wait3", perf_wait, 32'd3);
        chk("perf_fetched4", perf_fetched, 32'd4);
`endif

        // Decode stalls for five cycles.
        for (int k = 0; k < 5; k++) begin
            step();
            $display("stall cycle %0d", k);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, word_for(32'h10));
            chk("stall_pc", instr_pc, 32'h10);
            chk("stall_req", {31'd0, icache_req}, 32'd0);
            chk("stall_addr", icache_addr, 32'h14);
        end
        instr_ready = 1'b1;
        step();
        chk("resume_req", {31'd0, icache_req}, 32'd1);
        chk("resume_addr", icache_addr, 32'h14);
        chk("resume_valid", {31'd0, instr_valid}, 32'd0);

        for (int m = 0; m < 3; m++) begin
            a = 32'h14 + 32'(m * 4);
            icache_ack = 1'b1; icache_data = word_for(a);
            step();
            $display("fetch2 addr=%h", a);
            chk("run_pc", instr_pc, a);
            step();
        end

        // Redirect colliding with an ack at 0x20.
        chk("br_addr_before", icache_addr, 32'h20);
        icache_ack = 1'b1; icache_data = 32'hDEAD_BEEF;
        branch_taken = 1'b1; branch_target = 32'h103;
        step();
        $display("redirect to 0x103");
        branch_taken = 1'b0; icache_ack = 1'b0;
        chk("br_valid", {31'd0, instr_valid}, 32'd0);
        chk("br_addr", icache_addr, 32'h100);
        chk("br_req", {31'd0, icache_req}, 32'd1);
        step();
        chk("br_discard_valid", {31'd0, instr_valid}, 32'd0);
        chk("br_discard_instr", instr, word_for(32'h1C));
        icache_ack = 1'b1; icache_data = word_for(32'h100); instr_ready = 1'b0;
        step();
        chk("br_fetch_pc", instr_pc, 32'h100);
        chk("br_fetch_valid", {31'd0, instr_valid}, 32'd1);

        // Redirect in HOLD to the top of the address space, then wrap.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF; icache_ack = 1'b0;
        step();
        $display("redirect to 0xffffffff");
        branch_taken = 1'b0;
        chk("hold_br_valid", {31'd0, instr_valid}, 32'd0);
        chk("top_addr", icache_addr, 32'hFFFF_FFFC);
        icache_ack = 1'b1; icache_data = word_for(32'hFFFF_FFFC);
        step();
        chk("top_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", icache_addr, 32'h0);
        instr_ready = 1'b1; icache_ack = 1'b0;
        step();
        chk("wrap_req", {31'd0, icache_req}, 32'd1);
        chk("wrap_addr2", icache_addr, 32'h0);

        // fetch_en dropped mid-request: request completes, held instruction delivered, then idle.
        fetch_en = 1'b0;
        step();
        chk("en_off_req_held", {31'd0, icache_req}, 32'd1);
        icache_ack = 1'b1; icache_data = word_for(32'h0); instr_ready = 1'b0;
        step();
        chk("en_off_valid", {31'd0, instr_valid}, 32'd1);
        chk("en_off_pc", instr_pc, 32'h0);
        icache_ack = 1'b0;
        step();
        chk("en_off_hold", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        step();
        chk("idle_valid", {31'd0, instr_valid}, 32'd0);
        chk("idle_req", {31'd0, icache_req}, 32'd0);
        chk("idle_addr", icache_addr, 32'h4);
        step();
        chk("idle_req2", {31'd0, icache_req}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched10", perf_fetched, 32'd10);
        chk("perf_wait5", perf_wait, 32'd5);
`endif

        // Asynchronous reset between edges while in FETCH.
        fetch_en = 1'b1;
        step();
        chk("pre_rst_req", {31'd0, icache_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        $display("reset mid-fetch");
        chk("arst_req", {31'd0, icache_req}, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_addr", icache_addr, 32'h0);
        chk("arst_instr_pc", instr_pc, 32'h0);
        fetch_en = 1'b0; icache_ack = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_req", {31'd0, icache_req}, 32'd0);
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_rst_instr", instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_rst_fetched", perf_fetched, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
